isp_yhist: RTL and testbench
============================

ISP_YHIST -- requirements
Module: isp_yhist

Interface
REQ-001 SHALL have parameter BITS, default 8: pixel width.
REQ-002 SHALL have parameter WIDTH, default 1280: active pixels per line.
REQ-003 SHALL have parameter HEIGHT, default 720: active lines per frame.
REQ-004 SHALL have parameter HIST_BITS, default 6: bin index width, 2**HIST_BITS bins, bin = in_data[BITS-1 -: HIST_BITS].
REQ-005 SHALL have parameter CNT_BITS, default 21: bin counter width.
REQ-006 SHALL have ports `pclk in 1` (sole clock) and `rst in 1` (synchronous, active-high reset).
REQ-007 SHALL have ports `in_href in 1`, `in_vsync in 1` and `in_data in BITS`: DVP luma stream from the gamma stage.
REQ-008 SHALL have ports `out_href out 1`, `out_vsync out 1` and `out_data out BITS`: pass-through to the next stage.
REQ-009 SHALL have port `hist_en in 1`: accumulation enable, sampled at frame start.
REQ-010 SHALL have ports `hist_rd_addr in HIST_BITS` and `hist_rd_data out CNT_BITS`: read port on the completed bank.
REQ-011 SHALL have ports `hist_done out 1` (one-cycle pulse on bank swap) and `hist_ovr out 1` (sticky overrun flag).

Function
REQ-012 SHALL register out_href/out_vsync/out_data from in_* with exactly 1 cycle latency, unaffected by hist_en or state.
REQ-013 SHALL hold two banks of 2**HIST_BITS x CNT_BITS.
- Accumulate bank A = bank[sel], read bank R = bank[~sel].
- sel resets to 0.
REQ-014 SHALL implement FSM states IDLE, WAIT, ACCUM and CLEAR.
- Reset state is CLEAR on bank A.
REQ-015 SHALL perform CLEAR as one bin per cycle, addresses 0..2**HIST_BITS-1, then go to WAIT.
REQ-016 SHALL transition WAIT -> ACCUM on an in_vsync rising edge with hist_en=1.
- With hist_en=0, SHALL remain in WAIT and count nothing.
REQ-017 SHALL increment bin(in_data) of A by 1 in ACCUM for every cycle with in_href=1.
REQ-018 SHALL count in_href falling edges in ACCUM.
- When the count reaches HEIGHT: toggle sel, pulse hist_done 1 cycle later, enter CLEAR on the new A.
REQ-019 SHALL abort to WAIT on an in_vsync rising edge during ACCUM before HEIGHT lines are seen.
- Bank A is discarded and re-cleared, with no swap and no hist_done.
REQ-020 SHALL implement the increment as a read-modify-write pipeline (read, add, write) sustaining 1 pixel/cycle.
- Forwarding from in-flight writes SHALL ensure back-to-back identical bins are all counted (8 equal pixels -> +8).
REQ-021 SHALL saturate bin counters at 2**CNT_BITS-1 with no wrap.
REQ-022 SHALL ignore, during CLEAR, any pixel with in_href=1 and set hist_ovr.
- hist_ovr stays set until reset.
REQ-023 SHALL present hist_rd_data = R[hist_rd_addr] registered, 1 cycle latency.
- Contents remain stable until the next swap.
REQ-024 SHALL make a read in the swap cycle return the post-swap bank.
REQ-025 SHALL ignore IDLE as a runtime state: it is the default FSM case only, with a single-cycle exit to CLEAR.

Reset
REQ-026 SHALL, with rst=1 at a pclk edge, drive out_href, out_vsync, out_data, hist_rd_data, hist_done and hist_ovr to 0.
- It SHALL also set sel=0 and line count=0, and enter CLEAR.
REQ-027 SHALL abandon any accumulation when rst is asserted mid-frame.
- After release, bank A is cleared before the next frame is counted.
- Bank R contents are undefined until the first hist_done.

Configuration
REQ-028 SHALL, when ISP_YHIST_SUM_EN is defined, add port `hist_sum out BITS+CNT_BITS`.
- hist_sum is the sum of all in_data accumulated in the last completed frame.
- It is latched at swap and reset to 0.
REQ-029 SHALL, when ISP_YHIST_SUM_EN is undefined, have no hist_sum port and no sum logic; all other behaviour is identical.

Verification
(BITS=8, WIDTH=8, HEIGHT=4, HIST_BITS=4, CNT_BITS=8 unless noted)
REQ-030 SHALL cover: 32 pixels all 0x35 -> after hist_done, R[3]=32 and all other bins 0; out_* equals in_* delayed 1 cycle.
REQ-031 SHALL cover: ramp 0x00..0xF8 step 8 -> each bin = 2.
- With ISP_YHIST_SUM_EN: hist_sum = 3968.
REQ-032 SHALL cover: CNT_BITS=4, 32 pixels of 0xFF -> R[15]=15 (saturated).
REQ-033 SHALL cover: href asserted 3 cycles after a swap (inside CLEAR) -> hist_ovr=1; those pixels are not counted in the next frame.
REQ-034 SHALL cover: hist_en=0 at vsync -> no hist_done that frame, R unchanged; hist_en=1 the next frame -> normal result.
REQ-035 SHALL cover: rst pulsed after 2 lines -> all outputs 0 next cycle; the following full frame yields counts of that frame only.

Source files
------------

// File: rtl/isp_yhist.sv
// isp_yhist: luma histogram tap on a DVP stream.
// Passes the stream through with one cycle of latency while counting
// pixels into one of two histogram banks (accumulate / read), swapping
// the banks after HEIGHT complete lines.
// Optional feature: define ISP_YHIST_SUM_EN to add the hist_sum port
// (sum of all pixels counted in the last completed frame).
module isp_yhist #(
  parameter int unsigned BITS      = 8,
  parameter int unsigned WIDTH     = 1280,
  parameter int unsigned HEIGHT    = 720,
  parameter int unsigned HIST_BITS = 6,
  parameter int unsigned CNT_BITS  = 21
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  in_href,
  input  logic                  in_vsync,
  input  logic [BITS-1:0]       in_data,
  output logic                  out_href,
  output logic                  out_vsync,
  output logic [BITS-1:0]       out_data,
  input  logic                  hist_en,
  input  logic [HIST_BITS-1:0]  hist_rd_addr,
  output logic [CNT_BITS-1:0]   hist_rd_data,
  output logic                  hist_done,
  output logic                  hist_ovr
`ifdef ISP_YHIST_SUM_EN
  ,
  output logic [BITS+CNT_BITS-1:0] hist_sum
`endif
);

  localparam int unsigned NBINS  = 2 ** HIST_BITS;
  localparam int unsigned LINE_W = $clog2(HEIGHT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  // Reject configurations the bin slice or line counter cannot handle.
  if (HIST_BITS > BITS || WIDTH == 0 || HEIGHT == 0) begin : g_cfg_err
    $error("isp_yhist: invalid parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACCUM = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  sel_q, sel_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [HIST_BITS-1:0]  clr_addr_q, clr_addr_d;
  logic                  ovr_q, ovr_d;
  logic                  done_q, done_d;
  logic [CNT_BITS-1:0]   rd_q, rd_d;
  logic                  out_href_q, out_vsync_q;
  logic [BITS-1:0]       out_data_q;

  // Increment pipeline: p1 = read stage, p2 = write stage.
  logic                  p1_vld_q, p1_vld_d;
  logic                  p1_bank_q;
  logic [HIST_BITS-1:0]  p1_bin_q;
  logic                  p2_vld_q, p2_vld_d;
  logic                  p2_bank_q;
  logic [HIST_BITS-1:0]  p2_bin_q;
  logic [CNT_BITS-1:0]   p2_cnt_q;

  logic [CNT_BITS-1:0]   bank_mem [2][NBINS];

  logic                  vs_rise_c, hr_fall_c, last_line_c, clr_last_c;
  logic                  swap_c, abort_c, pix_c, clr_we_c, rd_bank_c;
  logic [CNT_BITS-1:0]   rmw_cur_c, rmw_inc_c;

  assign vs_rise_c   = in_vsync & ~out_vsync_q;
  assign hr_fall_c   = ~in_href & out_href_q;
  assign last_line_c = (line_q == LINE_W'(HEIGHT - 1));
  assign clr_last_c  = (clr_addr_q == HIST_BITS'(NBINS - 1));
  // A completed frame wins over a coincident vsync edge.
  assign swap_c  = (state_q == S_ACCUM) && hr_fall_c && last_line_c;
  assign abort_c = (state_q == S_ACCUM) && vs_rise_c && !swap_c;
  assign pix_c   = (state_q == S_ACCUM) && in_href && !vs_rise_c;

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (rst) state_q <= S_CLEAR;
    else     state_q <= state_d;
  end

  // FSM next state; an abort re-clears bank A before waiting again.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (vs_rise_c && hist_en) state_d = S_ACCUM;
      S_ACCUM: if (swap_c || abort_c)    state_d = S_CLEAR;
      S_CLEAR: if (clr_last_c)           state_d = S_WAIT;
      default: state_d = S_CLEAR;
    endcase
  end

  // FSM outputs: line count, bank select, clear sweep, flags.
  always_comb begin
    sel_d      = sel_q;
    line_d     = line_q;
    clr_addr_d = '0;
    ovr_d      = ovr_q;
    done_d     = 1'b0;
    clr_we_c   = 1'b0;
    case (state_q)
      S_WAIT: line_d = '0;
      S_ACCUM: begin
        if (hr_fall_c) line_d = line_q + LINE_W'(1);
        if (swap_c) begin
          sel_d  = ~sel_q;
          line_d = '0;
          done_d = 1'b1;
        end
        if (abort_c) line_d = '0;
      end
      S_CLEAR: begin
        clr_we_c   = 1'b1;
        clr_addr_d = clr_addr_q + HIST_BITS'(1);
        if (in_href) ovr_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Control registers and registered outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      sel_q       <= 1'b0;
      line_q      <= '0;
      clr_addr_q  <= '0;
      ovr_q       <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= '0;
      out_href_q  <= 1'b0;
      out_vsync_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      sel_q       <= sel_d;
      line_q      <= line_d;
      clr_addr_q  <= clr_addr_d;
      ovr_q       <= ovr_d;
      done_q      <= done_d;
      rd_q        <= rd_d;
      out_href_q  <= in_href;
      out_vsync_q <= in_vsync;
      out_data_q  <= in_data;
    end
  end

  // Read stage: current bin value, forwarded from the pending write.
  always_comb begin
    rmw_cur_c = bank_mem[p1_bank_q][p1_bin_q];
    if (p2_vld_q && (p2_bank_q == p1_bank_q) && (p2_bin_q == p1_bin_q))
      rmw_cur_c = p2_cnt_q;
    rmw_inc_c = (rmw_cur_c == CNT_MAX) ? rmw_cur_c : rmw_cur_c + CNT_BITS'(1);
  end

  // Pipeline valids; an abort drops in-flight pixels of the discarded frame.
  always_comb begin
    p1_vld_d = pix_c;
    p2_vld_d = p1_vld_q && !abort_c;
  end

  // Pipeline registers; each pixel carries its bank so a swap can't misroute it.
  always_ff @(posedge pclk) begin
    if (rst) begin
      p1_vld_q <= 1'b0;
      p2_vld_q <= 1'b0;
    end else begin
      p1_vld_q <= p1_vld_d;
      p2_vld_q <= p2_vld_d;
    end
    p1_bank_q <= sel_q;
    p1_bin_q  <= in_data[BITS-1 -: HIST_BITS];
    p2_bank_q <= p1_bank_q;
    p2_bin_q  <= p1_bin_q;
    p2_cnt_q  <= rmw_inc_c;
  end

  // Bank storage: clear sweep on bank A, write stage of the increment.
  always_ff @(posedge pclk) begin
    if (clr_we_c) bank_mem[sel_q][clr_addr_q] <= '0;
    if (p2_vld_q) bank_mem[p2_bank_q][p2_bin_q] <= p2_cnt_q;
  end

  // Read port on the post-swap read bank, including writes still draining.
  always_comb begin
    rd_bank_c = ~sel_d;
    rd_d      = bank_mem[rd_bank_c][hist_rd_addr];
    if (p2_vld_q && (p2_bank_q == rd_bank_c) && (p2_bin_q == hist_rd_addr))
      rd_d = p2_cnt_q;
    if (p1_vld_q && (p1_bank_q == rd_bank_c) && (p1_bin_q == hist_rd_addr))
      rd_d = rmw_inc_c;
  end

`ifdef ISP_YHIST_SUM_EN
  localparam int unsigned SUM_W = BITS + CNT_BITS;
  logic [SUM_W-1:0] acc_q, acc_d, sum_q, sum_d;

  // Frame pixel sum, latched into hist_sum at the bank swap.
  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    if (state_q == S_WAIT) acc_d = '0;
    else if (pix_c)        acc_d = acc_q + SUM_W'(in_data);
    if (swap_c) sum_d = acc_q;
  end

  // Sum registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign hist_sum = sum_q;
`endif

  assign out_href     = out_href_q;
  assign out_vsync    = out_vsync_q;
  assign out_data     = out_data_q;
  assign hist_rd_data = rd_q;
  assign hist_done    = done_q;
  assign hist_ovr     = ovr_q;

endmodule

// File: tb/tb_isp_yhist.sv
// Directed bench for isp_yhist: a full-width instance (CNT_BITS=8) and a
// narrow-counter instance (CNT_BITS=4) share one DVP stimulus stream.
module tb_isp_yhist;

  localparam int unsigned NB  = 16;
  localparam int unsigned NPX = 32;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic       rst, in_href, in_vsync, hist_en;
  logic [7:0] in_data;
  logic [3:0] hist_rd_addr;

  logic       m_href, m_vsync, m_done, m_ovr;
  logic [7:0] m_data, m_rd;
  logic       s_href, s_vsync, s_done, s_ovr;
  logic [7:0] s_data;
  logic [3:0] s_rd;
`ifdef ISP_YHIST_SUM_EN
  logic [15:0] m_sum;
  logic [11:0] s_sum;
`endif

  isp_yhist #(.BITS(8), .WIDTH(8), .HEIGHT(4), .HIST_BITS(4), .CNT_BITS(8)) u_main (
    .pclk(pclk), .rst(rst), .in_href(in_href), .in_vsync(in_vsync), .in_data(in_data),
    .out_href(m_href), .out_vsync(m_vsync), .out_data(m_data), .hist_en(hist_en),
    .hist_rd_addr(hist_rd_addr), .hist_rd_data(m_rd), .hist_done(m_done), .hist_ovr(m_ovr)
`ifdef ISP_YHIST_SUM_EN
    , .hist_sum(m_sum)
`endif
  );

  isp_yhist #(.BITS(8), .WIDTH(8), .HEIGHT(4), .HIST_BITS(4), .CNT_BITS(4)) u_sat (
    .pclk(pclk), .rst(rst), .in_href(in_href), .in_vsync(in_vsync), .in_data(in_data),
    .out_href(s_href), .out_vsync(s_vsync), .out_data(s_data), .hist_en(hist_en),
    .hist_rd_addr(hist_rd_addr), .hist_rd_data(s_rd), .hist_done(s_done), .hist_ovr(s_ovr)
`ifdef ISP_YHIST_SUM_EN
    , .hist_sum(s_sum)
`endif
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          done_m_cnt = 0;
  int          done_s_cnt = 0;
  logic [9:0]  pt_q[$];
  logic [11:0] rd_q[$];
  logic [7:0]  pix [NPX];
  int          exp_m [NB];
  int          exp_s [NB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the expected pass-through, check it after the edge.
  task automatic step(input logic h, input logic v, input logic [7:0] d);
    logic [9:0] e;
    in_href  = h;
    in_vsync = v;
    in_data  = d;
    pt_q.push_back(rst ? 10'd0 : {h, v, d});
    @(posedge pclk);
    #1;
    e = pt_q.pop_front();
    check("passthru", {22'd0, m_href, m_vsync, m_data}, {22'd0, e});
    if (m_done === 1'b1) done_m_cnt++;
    if (s_done === 1'b1) done_s_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  // Expected bins of the current pixel buffer, saturated per instance.
  task automatic calc_exp();
    int c [NB];
    for (int b = 0; b < NB; b++) c[b] = 0;
    for (int i = 0; i < NPX; i++) c[pix[i][7:4]]++;
    for (int b = 0; b < NB; b++) begin
      exp_m[b] = (c[b] > 255) ? 255 : c[b];
      exp_s[b] = (c[b] > 15) ? 15 : c[b];
    end
  endtask

  function automatic logic [31:0] pix_sum();
    logic [31:0] s = 0;
    for (int i = 0; i < NPX; i++) s += 32'(pix[i]);
    return s;
  endfunction

  // Frame: vsync pulse, n_lines lines of 8 pixels, optional href burst inside CLEAR.
  task automatic frame(input logic en, input int n_lines, input logic ovr_tail);
    hist_en = en;
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    idle(2);
    for (int l = 0; l < n_lines; l++) begin
      for (int p = 0; p < 8; p++) step(1'b1, 1'b0, pix[l*8+p]);
      idle(3);
    end
    if (ovr_tail) begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    end
    idle(20);
  endtask

  // Read every bin of both instances against the expected tables.
  task automatic read_all(input string tag);
    logic [11:0] e;
    for (int b = 0; b < NB; b++) begin
      hist_rd_addr = 4'(b);
      rd_q.push_back({4'(exp_s[b]), 8'(exp_m[b])});
      step(1'b0, 1'b0, 8'h00);
      e = rd_q.pop_front();
      check({tag, "_main"}, {24'd0, m_rd}, {24'd0, e[7:0]});
      check({tag, "_sat"},  {28'd0, s_rd}, {28'd0, e[11:8]});
    end
  endtask

  task automatic check_done(input string tag, input int m0, input int s0, input int n);
    check({tag, "_done_main"}, 32'(done_m_cnt - m0), 32'(n));
    check({tag, "_done_sat"},  32'(done_s_cnt - s0), 32'(n));
  endtask

  task automatic fill(input logic [7:0] base, input logic [7:0] inc);
    for (int i = 0; i < NPX; i++) pix[i] = base + 8'(i) * inc;
  endtask

  initial begin
    int m0, s0;
    rst = 1'b1;
    hist_en = 1'b1;
    hist_rd_addr = 4'd0;
    in_href = 1'b0;
    in_vsync = 1'b0;
    in_data = 8'h00;

    // Reset state.
    step(1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b0, 8'h5A);
    check("rst_rd", {24'd0, m_rd}, 32'd0);
    check("rst_done", {31'd0, m_done}, 32'd0);
    check("rst_ovr", {31'd0, m_ovr}, 32'd0);
`ifdef ISP_YHIST_SUM_EN
    check("rst_sum", {16'd0, m_sum}, 32'd0);
`endif
    rst = 1'b0;
    idle(20);

    // Constant 0x35 frame: everything lands in bin 3.
    fill(8'h35, 8'h00);
    calc_exp();
    m0 = done_m_cnt; s0 = done_s_cnt;
    frame(1'b1, 4, 1'b0);
    check_done("const", m0, s0, 1);
    check("const_ovr", {31'd0, m_ovr}, 32'd0);
    read_all("const");
`ifdef ISP_YHIST_SUM_EN
    check("const_sum", {16'd0, m_sum}, pix_sum());
`endif

    // Ramp 0x00..0xF8 step 8: two pixels per bin.
    fill(8'h00, 8'h08);
    calc_exp();
    m0 = done_m_cnt; s0 = done_s_cnt;
    frame(1'b1, 4, 1'b0);
    check_done("ramp", m0, s0, 1);
    read_all("ramp");
`ifdef ISP_YHIST_SUM_EN
    check("ramp_sum_main", {16'd0, m_sum}, 32'd3968);
    check("ramp_sum_sat", {20'd0, s_sum}, 32'd3968);
`endif

    // All 0xFF: 32 in the wide counter, saturates at 15 in the narrow one.
    fill(8'hFF, 8'h00);
    calc_exp();
    m0 = done_m_cnt; s0 = done_s_cnt;
    frame(1'b1, 4, 1'b0);
    check_done("sat", m0, s0, 1);
    read_all("sat");

    // href during CLEAR right after the swap raises the sticky overrun flag.
    fill(8'h35, 8'h00);
    m0 = done_m_cnt; s0 = done_s_cnt;
    frame(1'b1, 4, 1'b1);
    check_done("ovr", m0, s0, 1);
    check("ovr_set_main", {31'd0, m_ovr}, 32'd1);
    check("ovr_set_sat", {31'd0, s_ovr}, 32'd1);
    fill(8'hFF, 8'h00);
    calc_exp();
    m0 = done_m_cnt; s0 = done_s_cnt;
    frame(1'b1, 4, 1'b0);
    check_done("ovr_next", m0, s0, 1);
    read_all("ovr_next");
    check("ovr_sticky", {31'd0, m_ovr}, 32'd1);

    // hist_en low at vsync: no swap, read bank keeps the 0xFF frame.
    fill(8'h80, 8'h00);
    m0 = done_m_cnt; s0 = done_s_cnt;
    frame(1'b0, 4, 1'b0);
    check_done("dis", m0, s0, 0);
    read_all("dis_keep");
    fill(8'h00, 8'h08);
    calc_exp();
    m0 = done_m_cnt; s0 = done_s_cnt;
    frame(1'b1, 4, 1'b0);
    check_done("reen", m0, s0, 1);
    read_all("reen");

    // Reset after two lines: outputs clear, next frame counts only itself.
    fill(8'h10, 8'h00);
    m0 = done_m_cnt; s0 = done_s_cnt;
    frame(1'b1, 2, 1'b0);
    check_done("part", m0, s0, 0);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h10);
    check("mrst_rd", {24'd0, m_rd}, 32'd0);
    check("mrst_done", {31'd0, m_done}, 32'd0);
    check("mrst_ovr", {31'd0, m_ovr}, 32'd0);
    check("mrst_ovr_sat", {31'd0, s_ovr}, 32'd0);
`ifdef ISP_YHIST_SUM_EN
    check("mrst_sum", {16'd0, m_sum}, 32'd0);
`endif
    rst = 1'b0;
    idle(20);
    fill(8'h35, 8'h00);
    calc_exp();
    m0 = done_m_cnt; s0 = done_s_cnt;
    frame(1'b1, 4, 1'b0);
    check_done("post_rst", m0, s0, 1);
    read_all("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
